tc_program8_loader: RTL and testbench

- Writer side of the 8-bit program memory: takes a byte stream over a valid/ready handshake and emits sequential byte writes (address, data, write enable) into program RAM.
- The program memory's read port then returns those bytes at the same 16-bit addresses.
- Sits between the host/boot byte source and the program memory write port.
- Driven by a start command carrying a base address and a byte count.

---
 rtl/tc_program8_loader.sv | 134 +++++++++++++
 tb/tb_tc_program8_loader.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_program8_loader.sv
// tc_program8_loader
//   Writer side of the 8-bit program memory. A start command latches a base
//   address and a byte count. Payload bytes then arrive over a valid/ready
//   handshake. Each accepted byte becomes one registered write (address,
//   data, strobe) into program RAM on the following cycle.
//
// Optional build macro: TC_PROGRAM8_LOADER_CHECKSUM_EN
//   When defined, one trailing checksum byte follows the payload. It must
//   equal the mod-256 sum of the payload bytes. A mismatch sets error. The
//   checksum byte is never written to memory.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   start         load command, sampled only in IDLE
//   base_address  first write address, latched on an accepted start
//   length        payload byte count, latched on an accepted start
//   in_valid      source has a byte
//   in_data       payload byte
//   in_ready      loader accepts a byte this cycle (decoded from state only)
//   wr_en         program memory write strobe, high for one cycle per byte
//   wr_address    write address
//   wr_data       write data
//   busy          high in every state except IDLE
//   done          one-cycle pulse at the end of a load
//   error         sticky error (address wrap or bad checksum), cleared by start
module tc_program8_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_address,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_address,
  output logic [7:0]            wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state_reg;
  logic [ADDR_WIDTH-1:0] ptr_reg;
  logic [LEN_WIDTH-1:0]  cnt_reg;
`ifdef TC_PROGRAM8_LOADER_CHECKSUM_EN
  logic [7:0]            sum_reg;
`endif

  // The ready signal depends only on state. It never depends on in_valid,
  // so the source can never see a combinational loop through the loader.
  assign in_ready = (state_reg == S_LOAD) || (state_reg == S_CHECK);
  assign busy     = (state_reg != S_IDLE);
  assign done     = (state_reg == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      ptr_reg    <= '0;
      cnt_reg    <= '0;
      wr_en      <= 1'b0;
      wr_address <= '0;
      wr_data    <= '0;
      error      <= 1'b0;
`ifdef TC_PROGRAM8_LOADER_CHECKSUM_EN
      sum_reg    <= '0;
`endif
    end else begin
      // The strobe is a single-cycle pulse. Address and data hold between writes.
      wr_en <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            ptr_reg   <= base_address;
            cnt_reg   <= length;
            error     <= 1'b0;
`ifdef TC_PROGRAM8_LOADER_CHECKSUM_EN
            sum_reg   <= '0;
`endif
            state_reg <= (length == '0) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          // in_ready is high here, so in_valid alone means a handshake.
          if (in_valid) begin
            wr_en      <= 1'b1;
            wr_address <= ptr_reg;
            wr_data    <= in_data;
            ptr_reg    <= ptr_reg + ADDR_WIDTH'(1);
            cnt_reg    <= cnt_reg - LEN_WIDTH'(1);
            // Wrapping past the top of memory is flagged only when more bytes
            // would follow. The final byte landing at all-ones is legal.
            if ((ptr_reg == '1) && (cnt_reg > LEN_WIDTH'(1)))
              error <= 1'b1;
`ifdef TC_PROGRAM8_LOADER_CHECKSUM_EN
            sum_reg <= sum_reg + in_data;
            if (cnt_reg == LEN_WIDTH'(1))
              state_reg <= S_CHECK;
`else
            if (cnt_reg == LEN_WIDTH'(1))
              state_reg <= S_DONE;
`endif
          end
        end
`ifdef TC_PROGRAM8_LOADER_CHECKSUM_EN
        S_CHECK: begin
          // The trailer byte is compared against the sum and is not written.
          if (in_valid) begin
            if (in_data != sum_reg)
              error <= 1'b1;
            state_reg <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tc_program8_loader.sv
// tb_tc_program8_loader
//   Directed self-checking bench for tc_program8_loader. It contains a
//   behavioural program memory so that written bytes can be read back, and a
//   negedge monitor that logs every write with its cycle number.
module tb_tc_program8_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_address = '0;
  logic [15:0] length = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        wr_en;
  logic [15:0] wr_address;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int failures = 0;

  tc_program8_loader #(.ADDR_WIDTH(16), .LEN_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_address(base_address),
    .length(length), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_address(wr_address),
    .wr_data(wr_data), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Behavioural program memory fed by the loader's write port.
  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (wr_en) mem[wr_address] <= wr_data;
  end

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    int          c;
  } wr_t;

  wr_t wlog[$];
  int  cyc = 0;
  int  done_cnt = 0;
  bit  ready_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) wlog.push_back('{a: wr_address, d: wr_data, c: cyc});
      if (done) done_cnt++;
      if (in_ready) ready_seen = 1;
    end
  end

  task automatic clear_log();
    wlog.delete();
    done_cnt = 0;
    ready_seen = 0;
  endtask

  // Called at a negedge. Returns at the negedge after the handshake edge.
  task automatic do_start(input logic [15:0] b, input logic [15:0] l);
    start = 1'b1; base_address = b; length = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge. Presents one byte and returns once it has transferred.
  task automatic send(input logic [7:0] d);
    int t = 0;
    in_valid = 1'b1; in_data = d;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout byte=%h in_ready=%b required=1", d, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if ({in_ready, wr_en, busy, done, error} !== 5'b0 || wr_address !== 16'h0 || wr_data !== 8'h0) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b we=%b busy=%b done=%b err=%b addr=%h data=%h required all 0",
               in_ready, wr_en, busy, done, error, wr_address, wr_data);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_basic_load();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'hA1; exp_d[1] = 8'hB2; exp_d[2] = 8'hC3;
    clear_log();
    do_start(16'h0000, 16'd3);
    send(8'hA1); send(8'hB2); send(8'hC3);
    repeat (4) @(negedge clk);
    checks++;
    if (wlog.size() !== 3) begin
      failures++;
      $display("FAIL basic_count got=%0d required=3", wlog.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wlog[i].a !== 16'(i) || wlog[i].d !== exp_d[i]) begin
          failures++;
          $display("FAIL basic_write%0d got=(%h,%h) required=(%h,%h)", i, wlog[i].a, wlog[i].d, 16'(i), exp_d[i]);
        end
      end
      checks++;
      if (wlog[1].c != wlog[0].c + 1 || wlog[2].c != wlog[1].c + 1) begin
        failures++;
        $display("FAIL basic_consecutive cycles got=%0d,%0d,%0d required consecutive", wlog[0].c, wlog[1].c, wlog[2].c);
      end
    end
    checks++;
    if (done_cnt !== 1 || error !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_err done_cnt=%0d err=%b required 1,0", done_cnt, error);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem[i] !== exp_d[i]) begin
        failures++;
        $display("FAIL readback%0d got=%h required=%h", i, mem[i], exp_d[i]);
      end
    end
    $display("test_basic_load done writes=%0d", wlog.size());
  endtask

  task automatic test_stall();
    clear_log();
    do_start(16'h0010, 16'd2);
    send(8'h5E);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL stall_gap%0d we=%b busy=%b required 0,1", i, wr_en, busy);
      end
    end
    send(8'h6F);
    repeat (4) @(negedge clk);
    checks++;
    if (wlog.size() !== 2) begin
      failures++;
      $display("FAIL stall_count got=%0d required=2", wlog.size());
    end else begin
      checks++;
      if (wlog[0].a !== 16'h0010 || wlog[0].d !== 8'h5E || wlog[1].a !== 16'h0011 || wlog[1].d !== 8'h6F) begin
        failures++;
        $display("FAIL stall_writes got=(%h,%h),(%h,%h) required=(0010,5e),(0011,6f)",
                 wlog[0].a, wlog[0].d, wlog[1].a, wlog[1].d);
      end
    end
    $display("test_stall done writes=%0d", wlog.size());
  endtask

  task automatic test_wrap();
    clear_log();
    do_start(16'hFFFF, 16'd2);
    send(8'h5A);
    checks++;
    if (error !== 1'b1) begin
      failures++;
      $display("FAIL wrap_err_set got=%b required=1", error);
    end
    send(8'h3C);
    repeat (4) @(negedge clk);
    checks++;
    if (error !== 1'b1) begin
      failures++;
      $display("FAIL wrap_err_sticky got=%b required=1", error);
    end
    checks++;
    if (wlog.size() !== 2) begin
      failures++;
      $display("FAIL wrap_count got=%0d required=2", wlog.size());
    end else begin
      checks++;
      if (wlog[0].a !== 16'hFFFF || wlog[0].d !== 8'h5A || wlog[1].a !== 16'h0000 || wlog[1].d !== 8'h3C) begin
        failures++;
        $display("FAIL wrap_writes got=(%h,%h),(%h,%h) required=(ffff,5a),(0000,3c)",
                 wlog[0].a, wlog[0].d, wlog[1].a, wlog[1].d);
      end
    end
    $display("test_wrap done err=%b", error);
  endtask

  task automatic test_zero_length();
    clear_log();
    do_start(16'h1234, 16'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL zero_done_pulse done=%b busy=%b required 1,1", done, busy);
    end
    checks++;
    if (error !== 1'b0) begin
      failures++;
      $display("FAIL zero_err_cleared got=%b required=0", error);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt !== 1 || wlog.size() !== 0 || ready_seen !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_summary done_cnt=%0d writes=%0d ready_seen=%b busy=%b required 1,0,0,0",
               done_cnt, wlog.size(), ready_seen, busy);
    end
    $display("test_zero_length done");
  endtask

  task automatic test_start_ignored();
    logic [7:0] exp_d [4];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;
    clear_log();
    do_start(16'h0100, 16'd4);
    send(8'h11);
    start = 1'b1; base_address = 16'h0200; length = 16'd9;
    send(8'h22); send(8'h33);
    start = 1'b0;
    send(8'h44);
    repeat (4) @(negedge clk);
    checks++;
    if (wlog.size() !== 4 || done_cnt !== 1) begin
      failures++;
      $display("FAIL ignore_count writes=%0d done_cnt=%0d required 4,1", wlog.size(), done_cnt);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wlog[i].a !== 16'h0100 + 16'(i) || wlog[i].d !== exp_d[i]) begin
          failures++;
          $display("FAIL ignore_write%0d got=(%h,%h) required=(%h,%h)", i, wlog[i].a, wlog[i].d,
                   16'h0100 + 16'(i), exp_d[i]);
        end
      end
    end
    $display("test_start_ignored done writes=%0d", wlog.size());
  endtask

  task automatic test_reset_midload();
    clear_log();
    do_start(16'h0040, 16'd4);
    send(8'hE1); send(8'hE2);
    @(negedge clk);
    clear_log();
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, wr_en, busy, done, error} !== 5'b0 || wr_address !== 16'h0 || wr_data !== 8'h0) begin
      failures++;
      $display("FAIL midreset_outputs rdy=%b we=%b busy=%b done=%b err=%b addr=%h data=%h required all 0",
               in_ready, wr_en, busy, done, error, wr_address, wr_data);
    end
    in_valid = 1'b1; in_data = 8'h99;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (wlog.size() !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_nowrites writes=%0d busy=%b required 0,0", wlog.size(), busy);
    end
    do_start(16'h0050, 16'd1);
    send(8'h77);
    repeat (3) @(negedge clk);
    checks++;
    if (wlog.size() !== 1) begin
      failures++;
      $display("FAIL midreset_reload_count got=%0d required=1", wlog.size());
    end else begin
      checks++;
      if (wlog[0].a !== 16'h0050 || wlog[0].d !== 8'h77) begin
        failures++;
        $display("FAIL midreset_reload got=(%h,%h) required=(0050,77)", wlog[0].a, wlog[0].d);
      end
    end
    $display("test_reset_midload done");
  endtask

`ifdef TC_PROGRAM8_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    for (int k = 0; k < 2; k++) begin
      logic [7:0] trailer;
      logic       exp_err;
      trailer = (k == 0) ? 8'h06 : 8'h07;
      exp_err = (k == 0) ? 1'b0 : 1'b1;
      clear_log();
      do_start(16'h0200, 16'd3);
      send(8'h01); send(8'h02); send(8'h03);
      send(trailer);
      repeat (4) @(negedge clk);
      checks++;
      if (error !== exp_err || wlog.size() !== 3 || done_cnt !== 1) begin
        failures++;
        $display("FAIL checksum_trailer_%h err=%b writes=%0d done_cnt=%0d required %b,3,1",
                 trailer, error, wlog.size(), done_cnt, exp_err);
      end
      $display("test_checksum trailer=%h err=%b writes=%0d", trailer, error, wlog.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_stall();
    test_wrap();
    test_zero_length();
    test_start_ignored();
    test_reset_midload();
`ifdef TC_PROGRAM8_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
